// File: rtl/sm_pkg.sv
// Shared types and constants for the sum-every-3 stream: the summing stage and its collect buffer.
package sm_pkg;

  localparam int SUM_W = 6;

  typedef logic [SUM_W-1:0] sum_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  // Increment that sticks at DROP_MAX instead of wrapping to zero.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == DROP_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sm_fifo_ctl.sv
// FIFO control for sm_collect: pointers, occupancy and the accept/drop decision.
// The fill state is implied by the occupancy count.
module sm_fifo_ctl
  import sm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_rdy,
  output logic [AW-1:0] wp,
  output logic [AW-1:0] rp,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          push_acc,
  output logic          pop,
  output logic          drop
);

  logic [AW-1:0] wp_r, wp_nxt_s;
  logic [AW-1:0] rp_r, rp_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  fifo_state_e   state_s;
  logic          full_s, empty_s, pop_s, push_acc_s, drop_s;

  // Decode the fill state from the registered occupancy.
  always_comb begin
    state_s = FIFO_PARTIAL;
    if (cnt_r == {CW{1'b0}}) begin
      state_s = FIFO_EMPTY;
    end else if (cnt_r == CW'(DEPTH)) begin
      state_s = FIFO_FULL;
    end else begin
      state_s = FIFO_PARTIAL;
    end
  end

  // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
  always_comb begin
    full_s     = (state_s == FIFO_FULL);
    empty_s    = (state_s == FIFO_EMPTY);
    pop_s      = ~empty_s & pop_rdy;
    push_acc_s = push_req & (~full_s | pop_s);
    drop_s     = push_req & full_s & ~pop_s;
  end

  // Next pointer and count values.
  always_comb begin
    wp_nxt_s  = wp_r;
    rp_nxt_s  = rp_r;
    cnt_nxt_s = cnt_r;
    if (push_acc_s) begin
      wp_nxt_s = wp_r + AW'(1'b1);
    end else begin
      wp_nxt_s = wp_r;
    end
    if (pop_s) begin
      rp_nxt_s = rp_r + AW'(1'b1);
    end else begin
      rp_nxt_s = rp_r;
    end
    case ({push_acc_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_r  <= {AW{1'b0}};
      rp_r  <= {AW{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else begin
      wp_r  <= wp_nxt_s;
      rp_r  <= rp_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign wp       = wp_r;
  assign rp       = rp_r;
  assign cnt      = cnt_r;
  assign full     = full_s;
  assign empty    = empty_s;
  assign push_acc = push_acc_s;
  assign pop      = pop_s;
  assign drop     = drop_s;

endmodule

// File: rtl/sm_collect.sv
// Collect buffer behind the summing stage: small FIFO with valid/ready output,
// overflow drops counted in a saturating counter and a sticky flag.
module sm_collect
  import sm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = SUM_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_dval,
  input  logic [DW-1:0] i,
  output logic          o_dval,
  input  logic          i_rdy,
  output logic [DW-1:0] o,
  output logic [CW-1:0] o_cnt,
  output logic          o_ovf,
  output logic [7:0]    o_drop
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wp_s, rp_s;
  logic [CW-1:0] cnt_s;
  logic          full_s, empty_s, push_acc_s, pop_s, drop_s;
  logic          ovf_r;
  logic [7:0]    drop_cnt_r;
  logic [DW-1:0] head_s;

  sm_fifo_ctl #(
    .DEPTH (DEPTH)
  ) u_ctl (
    .clk      (clk),
    .rst      (rst),
    .push_req (i_dval),
    .pop_rdy  (i_rdy),
    .wp       (wp_s),
    .rp       (rp_s),
    .cnt      (cnt_s),
    .full     (full_s),
    .empty    (empty_s),
    .push_acc (push_acc_s),
    .pop      (pop_s),
    .drop     (drop_s)
  );

  // Storage array; written only on an accepted push, so a dropped sum never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {DW{1'b0}};
      end
    end else if (push_acc_s) begin
      mem_r[wp_s] <= i;
    end else begin
      mem_r[wp_s] <= mem_r[wp_s];
    end
  end

  // Overflow bookkeeping; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      ovf_r      <= 1'b1;
      drop_cnt_r <= sat_inc8(drop_cnt_r);
    end else begin
      ovf_r      <= ovf_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // Head mux reads registered state only; forced to zero while empty.
  always_comb begin
    head_s = {DW{1'b0}};
    if (empty_s) begin
      head_s = {DW{1'b0}};
    end else begin
      head_s = mem_r[rp_s];
    end
  end

  assign o      = head_s;
  assign o_dval = ~empty_s;
  assign o_cnt  = cnt_s;
  assign o_ovf  = ovf_r;
  assign o_drop = drop_cnt_r;

  logic unused_s;
  assign unused_s = full_s ^ pop_s;

endmodule

// File: doc/sm_collect.md
# sm_collect

Downstream buffer stage for the sum-every-3 stream. It captures each 6-bit sum produced by the summing stage whenever that stage asserts its data-valid. It holds the sums in a small FIFO and presents them to a consumer over a valid/ready handshake. The summing stage has no backpressure, so overflow drops the incoming sum, sets a sticky flag and increments a saturating drop counter.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- DW, 6, sum width; matches the summing stage output (max sum 3×15 = 45)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- i_dval  input  1  a sum is present on i this cycle; no backpressure upstream
- i  input  DW  sum from the summing stage
- o_dval  output  1  FIFO non-empty; o is valid
- i_rdy  input  1  consumer accepts o this cycle; pop = o_dval & i_rdy
- o  output  DW  head-of-FIFO sum; 0 while empty
- o_cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- o_ovf  output  1  sticky; set on the first dropped sum
- o_drop  output  8  count of dropped sums, saturates at 255

## Operation
- Storage: DEPTH×DW array, write pointer wp and read pointer rp of $clog2(DEPTH) bits, wrap modulo DEPTH, plus an occupancy counter cnt.
- Push request = i_dval. Pop = o_dval & i_rdy.
- Accept a push when cnt < DEPTH, or when cnt == DEPTH and a pop occurs in the same cycle. Push when full with no pop is a drop.
- On a drop:
  - Array, wp and cnt are unchanged.
  - o_ovf ← 1.
  - o_drop ← o_drop+1 unless it already reads 255.
- Simultaneous accepted push and pop: cnt unchanged, wp and rp both advance.
- Push into an empty FIFO: no same-cycle bypass. The value appears on o the following cycle.
- i_rdy with o_dval=0 is ignored. No pointer or count change.
- Data is opaque. No arithmetic on the value; width DW is passed through unchanged.
- o_ovf and o_drop clear only on rst.
- States are implicit in cnt: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY→PARTIAL on push without pop.
  - PARTIAL→FULL on push without pop at cnt = DEPTH-1.
  - FULL→PARTIAL on pop without accepted push.
  - PARTIAL→EMPTY on pop without push at cnt = 1.

## Timing
- Reset values: o_dval 0, o 0, o_cnt 0, o_ovf 0, o_drop 0. wp and rp are 0 and the array is cleared.
- Reset asserted mid-operation: all buffered sums are discarded immediately (asynchronous). Outputs return to reset values within the same cycle.
- Latency: a sum with i_dval at edge N is visible on o with o_dval=1 after edge N+1, provided it is at the head.
- o, o_dval and o_cnt derive from registered state only, with no combinational path from i or i_dval. o_dval = (cnt != 0).
- i_rdy affects only next-state logic. There is no combinational path from i_rdy to any output.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Shared package sm_pkg:
  - localparam SUM_W = 6.
  - typedef logic [SUM_W-1:0] sum_t.
  - localparam DROP_MAX = 8'd255.
- The summing stage and this block both import sm_pkg.
- One sub-module, sm_fifo_ctl: pointers, cnt, accept/drop decision and the full/empty flags.
- The top level, sm_collect, holds the array, the o mux and the o_ovf/o_drop bookkeeping.

## Test plan
- Basic flow:
  - Stimulus: reset, then push 12, 45, 0 on consecutive cycles with i_rdy=1.
  - Response: o shows 12, 45, 0 on consecutive cycles, each one cycle after its push; o_cnt never exceeds 1; o_ovf=0.
- Fill and drain:
  - Stimulus: i_rdy=0, push 1,2,3,4; then push 5.
  - Response: after the first four, o_cnt=4 and o=1. On the fifth push, o_ovf=1, o_drop=1, o_cnt stays 4. Raising i_rdy then yields 1,2,3,4 only.
- Full with simultaneous push and pop:
  - Stimulus: FIFO holds 10,11,12,13; push 14 in the same cycle as i_rdy=1.
  - Response: no drop, o_cnt stays 4, output sequence 11,12,13,14.
- Drop saturation:
  - Stimulus: with the FIFO full and i_rdy=0, push 300 sums.
  - Response: o_drop=255 and o_ovf=1; FIFO contents unchanged.
- Wrap-around:
  - Stimulus: random push/pop for 1000 cycles against a scoreboard model.
  - Response: order is preserved across many pointer wraps. Every accepted value appears exactly once; dropped values never appear.
- Reset mid-stream:
  - Stimulus: assert rst between clock edges with o_cnt=3 and o_ovf=1.
  - Response: o_dval, o_cnt, o_ovf and o_drop read 0 before the next edge. A push after release appears as the first output.
